// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - button pins in, press/repeat pulses and debounced levels out
interface btn_conditioner_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] repeat_en;
  logic [N_BTN-1:0] button_bus;
  logic [N_BTN-1:0] btn_level;

  modport master (
    output btn_raw,
    output repeat_en,
    input  button_bus,
    input  btn_level
  );

  modport slave (
    input  btn_raw,
    input  repeat_en,
    output button_bus,
    output btn_level
  );
endinterface

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - per-channel sync, debounce, press pulse and auto-repeat
// for the five clock-setting buttons.
module btn_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input logic              clk,
  input logic              rst_n,
  btn_conditioner_if.slave bus
);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DBW      = $clog2(DEBOUNCE_CYCLES);
  localparam int HBW      = $clog2(HOLD_MAX);

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HBW-1:0] DELAY_LAST = HBW'(REPEAT_DELAY - 1);
  localparam logic [HBW-1:0] RATE_LAST  = HBW'(REPEAT_RATE - 1);

  logic [N_BTN-1:0] s1_q, s2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  // phase_q set once the first (delay) repeat has fired; later repeats use the rate
  logic [N_BTN-1:0] phase_q, phase_d;
  logic [DBW-1:0]   db_cnt_q   [N_BTN];
  logic [DBW-1:0]   db_cnt_d   [N_BTN];
  logic [HBW-1:0]   hold_cnt_q [N_BTN];
  logic [HBW-1:0]   hold_cnt_d [N_BTN];

  always_comb begin
    level_d    = level_q;
    pulse_d    = '0;
    phase_d    = phase_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (s2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        level_d[i]  = s2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end

      pulse_d[i] = ~level_q[i] & level_d[i];

      // Hold counting only while the level stays high across this edge, so the
      // press edge starts from zero and the release edge can never repeat.
      if (!(level_q[i] && level_d[i]) || !bus.repeat_en[i]) begin
        hold_cnt_d[i] = '0;
        phase_d[i]    = 1'b0;
      end else if (hold_cnt_q[i] == (phase_q[i] ? RATE_LAST : DELAY_LAST)) begin
        hold_cnt_d[i] = '0;
        phase_d[i]    = 1'b1;
        pulse_d[i]    = 1'b1;
      end else begin
        hold_cnt_d[i] = hold_cnt_q[i] + HBW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      pulse_q <= '0;
      phase_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      s1_q       <= bus.btn_raw;
      s2_q       <= s1_q;
      level_q    <= level_d;
      pulse_q    <= pulse_d;
      phase_q    <= phase_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.button_bus = pulse_q;
  assign bus.btn_level  = level_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed checks of btn_conditioner with DEBOUNCE=4, DELAY=10, RATE=3
module tb_btn_conditioner;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [4:0] e_bus;
  logic [4:0] e_lvl;

  btn_conditioner_if #(.N_BTN(5)) bif ();

  btn_conditioner #(
    .N_BTN(5),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bif.btn_raw = '0;
    bif.repeat_en = '0;
    repeat (3) tick();
    chk("reset_bus", bif.button_bus, 5'b0);
    chk("reset_level", bif.btn_level, 5'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Clean press on channel 0, repeat disabled
    bif.btn_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e_bus = (k == 6) ? 5'b00001 : 5'b00000;
      e_lvl = (k >= 6) ? 5'b00001 : 5'b00000;
      chk($sformatf("press_bus_%0d", k), bif.button_bus, e_bus);
      chk($sformatf("press_lvl_%0d", k), bif.btn_level, e_lvl);
    end
    bif.btn_raw[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e_lvl = (k < 6) ? 5'b00001 : 5'b00000;
      chk($sformatf("release_bus_%0d", k), bif.button_bus, 5'b0);
      chk($sformatf("release_lvl_%0d", k), bif.btn_level, e_lvl);
    end

    // Bounce on channel 2 never reaches four stable cycles
    bif.btn_raw[2] = 1'b1; repeat (3) tick();
    bif.btn_raw[2] = 1'b0; repeat (2) tick();
    bif.btn_raw[2] = 1'b1; repeat (2) tick();
    bif.btn_raw[2] = 1'b0;
    chk("bounce_lvl_early", bif.btn_level, 5'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("bounce_bus_%0d", k), bif.button_bus, 5'b0);
      chk($sformatf("bounce_lvl_%0d", k), bif.btn_level, 5'b0);
    end

    // Auto-repeat on channel 4: press at 6, repeats at 16,19,...,34, level falls after 35
    bif.repeat_en[4] = 1'b1;
    bif.btn_raw[4] = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 30) bif.btn_raw[4] = 1'b0;
      e_bus = (k == 6 || k == 16 || k == 19 || k == 22 || k == 25 ||
               k == 28 || k == 31 || k == 34) ? 5'b10000 : 5'b00000;
      e_lvl = (k >= 6 && k <= 35) ? 5'b10000 : 5'b00000;
      chk($sformatf("repeat_bus_%0d", k), bif.button_bus, e_bus);
      chk($sformatf("repeat_lvl_%0d", k), bif.btn_level, e_lvl);
    end
    bif.repeat_en[4] = 1'b0;
    repeat (4) tick();

    // Repeat enable drops at P+12, returns at P+15: pulses at 6, 16, 31, 34
    bif.repeat_en[4] = 1'b1;
    bif.btn_raw[4] = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 30) bif.btn_raw[4] = 1'b0;
      if (k == 18) bif.repeat_en[4] = 1'b0;
      if (k == 21) bif.repeat_en[4] = 1'b1;
      e_bus = (k == 6 || k == 16 || k == 31 || k == 34) ? 5'b10000 : 5'b00000;
      e_lvl = (k >= 6 && k <= 35) ? 5'b10000 : 5'b00000;
      chk($sformatf("gate_bus_%0d", k), bif.button_bus, e_bus);
      chk($sformatf("gate_lvl_%0d", k), bif.btn_level, e_lvl);
    end
    bif.repeat_en[4] = 1'b0;
    repeat (4) tick();

    // Simultaneous press on channels 1 and 3
    bif.btn_raw[1] = 1'b1;
    bif.btn_raw[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e_bus = (k == 6) ? 5'b01010 : 5'b00000;
      e_lvl = (k >= 6) ? 5'b01010 : 5'b00000;
      chk($sformatf("simul_bus_%0d", k), bif.button_bus, e_bus);
      chk($sformatf("simul_lvl_%0d", k), bif.btn_level, e_lvl);
    end
    bif.btn_raw[1] = 1'b0;
    bif.btn_raw[3] = 1'b0;
    repeat (8) tick();
    chk("simul_released", bif.btn_level, 5'b0);

    // Reset mid-hold on channel 0 with repeat enabled
    bif.repeat_en[0] = 1'b1;
    bif.btn_raw[0] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      e_bus = (k == 6) ? 5'b00001 : 5'b00000;
      e_lvl = (k >= 6) ? 5'b00001 : 5'b00000;
      chk($sformatf("prerst_bus_%0d", k), bif.button_bus, e_bus);
      chk($sformatf("prerst_lvl_%0d", k), bif.btn_level, e_lvl);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_lvl", bif.btn_level, 5'b0);
    chk("async_rst_bus", bif.button_bus, 5'b0);
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk($sformatf("inrst_lvl_%0d", k), bif.btn_level, 5'b0);
      chk($sformatf("inrst_bus_%0d", k), bif.button_bus, 5'b0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      e_bus = (k == 6 || k == 16 || k == 19) ? 5'b00001 : 5'b00000;
      e_lvl = (k >= 6) ? 5'b00001 : 5'b00000;
      chk($sformatf("postrst_bus_%0d", k), bif.button_bus, e_bus);
      chk($sformatf("postrst_lvl_%0d", k), bif.btn_level, e_lvl);
    end
    bif.btn_raw[0] = 1'b0;
    bif.repeat_en[0] = 1'b0;
    repeat (8) tick();
    chk("final_level", bif.btn_level, 5'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
